lut_product_accumulator: RTL



---
 rtl/lut_product_accumulator.sv | 108 ++++++++++
 1 files changed

// File: rtl/lut_product_accumulator.sv
// Accumulate stage for the constant LUT multiplier: sums a burst of cfg_len products
// and hands the registered sum downstream. Define LUTACC_SAT_EN to clamp instead of wrap.
module lut_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and the payload is held stable while valid & !ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             beat;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_inc;
  logic [ACC_W:0]   sum_w;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

  assign beat    = in_valid & in_ready;
  assign len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign sum_w   = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, in_data};
  assign carry   = sum_w[ACC_W];

`ifdef LUTACC_SAT_EN
  // Once clamped, every later add carries again, so the clamp holds for the burst.
  assign acc_next = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign acc_next = sum_w[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          len_d   = len_eff;
          acc_d   = {{(ACC_W-16){1'b0}}, in_data};
          cnt_d   = LEN_W'(1);
          ovf_d   = 1'b0;
          state_d = (len_eff == LEN_W'(1)) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = acc_next;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
